vigenere_stream_cipher: RTL and testbench
=========================================

# vigenere_stream_cipher

Parametrised, streaming successor to the Caesar/Vigenère environments. It encrypts or decrypts one 8-bit ASCII character per clock using a loadable key of up to `KEY_LEN` characters, with a runtime-selectable active key length. It uses valid/ready handshakes on input and output so it can sit between a character source (UART RX / ROM) and a sink (UART TX / display driver) with backpressure.

## Interface
- `KEY_LEN`, default 10: maximum key characters stored; `key_in` is `KEY_LEN*8` bits wide.
- `IDX_W`, default 4: width of `key_len` and the key index; must satisfy 2^IDX_W > KEY_LEN.
- `CLK` input, 1: single clock, rising-edge.
- `RST_N` input, 1: asynchronous, active-low reset.
- `LOAD` input, 1: synchronous key load strobe.
- `key_in` input, `KEY_LEN*8`: key characters; char 0 in [7:0], char i in [8i+7:8i].
- `key_len` input, `IDX_W`: active key length, sampled on `LOAD`.
- `mode` input, 1: 0 = encrypt, 1 = decrypt; sampled per accepted character.
- `in_valid` input, 1: `in_char` valid.
- `in_ready` output, 1: block accepts `in_char` this cycle.
- `in_char` input, 8: plaintext or ciphertext character.
- `out_valid` output, 1: `out_char` valid.
- `out_ready` input, 1: sink accepts `out_char` this cycle.
- `out_char` output, 8: transformed character.
- `keyed` output, 1: a key has been loaded since reset.
- `char_count` output, 16: number of letters transformed since last `LOAD`/reset (wraps at 65535→0).

## Operation
- FSM states: NOKEY (after reset), RUN (output register empty), HOLD (output register full, `out_ready`=0).
- NOKEY: `in_ready`=0. `LOAD`=1 goes to RUN.
- RUN/HOLD: `in_ready` = !`out_valid` || `out_ready`, and is also 0 in any cycle with `LOAD`=1.
- LOAD, on a rising edge:
  - Store `key_in`; index ← 0; `char_count` ← 0; `out_valid` ← 0 (pending output discarded); `keyed` ← 1; next state RUN.
  - Effective length ← `key_len`, clamped: 0 → 1, > `KEY_LEN` → `KEY_LEN`.
  - `LOAD` has priority over any handshake in the same cycle.
- Key shift k_i = key byte − 65 if the byte is in 65..90 ('A'..'Z'), else 0.
- Accepted letter p in 65..90:
  - Encrypt: out = 65 + ((p − 65 + k) mod 26).
  - Decrypt: out = 65 + ((p − 65 − k + 26) mod 26).
  - Arithmetic is 6-bit unsigned with a single conditional subtract of 26; no divider.
  - Index advances, wrapping from effective length − 1 to 0; `char_count` increments.
- Accepted non-letter (anything outside 65..90): passed through unchanged; index and `char_count` do not change.
- Accept and drain in the same cycle: the new result replaces the old one and `out_valid` stays 1 (full throughput).
- While `out_valid`=1 and `out_ready`=0, `out_char` is held stable.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_char`=8'h00, `keyed`=0, `char_count`=0, index=0, key registers=0, state NOKEY.
- Latency is 1 cycle: a character accepted on edge n appears with `out_valid`=1 after edge n.
- Throughput is 1 character/cycle while `out_ready`=1.
- `in_ready` is combinational from `out_ready`, `out_valid`, `LOAD` and state only; there is no path from `in_valid`.
- `RST_N` asserted mid-stream: all state returns to reset values immediately; a new `LOAD` is required before any character is accepted.
- `mode` changes take effect on the next accepted character; the key index is not reset.

## Test plan
- Key "LEMON", `key_len`=5, `LOAD`, encrypt stream "ATTACKATDAWN" with `out_ready`=1 → "LXFOPVEFRNHR" on consecutive cycles; `char_count`=12.
- Reload same key, `mode`=1, stream "LXFOPVEFRNHR" → "ATTACKATDAWN".
- Key "B", `key_len`=1, encrypt "Z" → "A"; decrypt "A" → "Z" (wrap-around in both directions).
- Key "LEMON", encrypt "A A" (65, 32, 65) → 76, 32, 69; the space does not advance the index; `char_count`=2.
- Backpressure: `out_ready`=0 for 3 cycles after the first output → `in_ready`=0, `out_char` stable; no characters lost or duplicated after `out_ready`=1.
- `key_len`=0 and `key_len`=15 with `KEY_LEN`=10 → lengths behave as 1 and 10; pulse `RST_N` low mid-stream → `out_valid`=0, `keyed`=0, `in_ready`=0 until the next `LOAD`.

Source files
------------

// File: rtl/vigenere_stream_cipher.sv
// Streaming Vigenere encrypt/decrypt, one ASCII char per clock, with valid/ready on both sides.
// Letters 'A'..'Z' are shifted by the current key char; all other bytes pass through unchanged.
module vigenere_stream_cipher #(
   parameter int KEY_LEN = 10,
   parameter int IDX_W   = 4
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 LOAD,
   input  logic [KEY_LEN*8-1:0] key_in,
   input  logic [IDX_W-1:0]     key_len,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_char,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           out_char,
   output logic                 keyed,
   output logic [15:0]          char_count
);

   typedef enum logic [1:0] {NOKEY, RUN, HOLD} state_t;

   state_t               state, nextState;
   logic [KEY_LEN*8-1:0] keyReg;
   logic [IDX_W-1:0]     effLen, idx, lenClamped;
   logic [7:0]           keyByte, cipherChar;
   logic [4:0]           shift;
   logic [5:0]           pOff, sum, wrapped;
   logic                 accept, inIsLetter, keyIsLetter;

   // Key char at the current index; idx never exceeds KEY_LEN-1
   always_comb begin
      keyByte = '0;
      for (int i = 0; i < KEY_LEN; i++)
         if (idx == IDX_W'(i)) keyByte = keyReg[i*8 +: 8];
   end

   assign keyIsLetter = (keyByte >= 8'd65) && (keyByte <= 8'd90);
   assign inIsLetter  = (in_char >= 8'd65) && (in_char <= 8'd90);
   assign shift       = keyIsLetter ? 5'(keyByte - 8'd65) : 5'd0;
   assign pOff        = 6'(in_char - 8'd65);

   // Decrypt biases by +26 so the 6-bit sum never underflows; one subtract folds it back
   assign sum        = mode ? (pOff + 6'd26 - {1'b0, shift}) : (pOff + {1'b0, shift});
   assign wrapped    = (sum >= 6'd26) ? (sum - 6'd26) : sum;
   assign cipherChar = inIsLetter ? (8'd65 + {2'b00, wrapped}) : in_char;

   assign lenClamped = (key_len == '0) ? IDX_W'(1) :
                       (key_len > IDX_W'(KEY_LEN)) ? IDX_W'(KEY_LEN) : key_len;

   assign out_valid = (state == HOLD);
   assign in_ready  = (state != NOKEY) && !LOAD && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;

   always_comb begin
      nextState = state;
      case (state)
         NOKEY:     if (LOAD) nextState = RUN;
         RUN, HOLD: begin
            if (LOAD)           nextState = RUN;
            else if (accept)    nextState = HOLD;
            else if (out_ready) nextState = RUN;
         end
         default:   nextState = NOKEY;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= NOKEY;
      else        state <= nextState;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         keyReg     <= '0;
         effLen     <= IDX_W'(1);
         idx        <= '0;
         char_count <= '0;
         keyed      <= 1'b0;
         out_char   <= 8'h00;
      end else if (LOAD) begin
         keyReg     <= key_in;
         effLen     <= lenClamped;
         idx        <= '0;
         char_count <= '0;
         keyed      <= 1'b1;
      end else if (accept) begin
         out_char <= cipherChar;
         if (inIsLetter) begin
            idx        <= (idx == effLen - IDX_W'(1)) ? '0 : idx + IDX_W'(1);
            char_count <= char_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// Scoreboard bench: driver pushes hand-computed expected chars on accept, monitor pops on output transfer.
module tb_vigenere_stream_cipher;

   localparam int KEY_LEN = 10;
   localparam int IDX_W   = 4;

   logic                 CLK = 1'b0;
   logic                 RST_N = 1'b0;
   logic                 LOAD = 1'b0;
   logic [KEY_LEN*8-1:0] key_in = '0;
   logic [IDX_W-1:0]     key_len = '0;
   logic                 mode = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [7:0]           in_char = 8'h00;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [7:0]           out_char;
   logic                 keyed;
   logic [15:0]          char_count;

   int       cmpCount = 0;
   int       errCount = 0;
   logic [7:0] sb[$];

   vigenere_stream_cipher #(.KEY_LEN(KEY_LEN), .IDX_W(IDX_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .key_in(key_in), .key_len(key_len),
      .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
      .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
      .keyed(keyed), .char_count(char_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmpCount++;
      if (act !== exp) begin
         errCount++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Output transfers at the next rising edge when valid&&ready are seen here
   initial forever begin
      @(negedge CLK);
      if (RST_N && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            cmpCount++;
            errCount++;
            $display("FAIL unexpected_output: got %0d expected none", out_char);
         end else begin
            check("out_char", {24'd0, out_char}, {24'd0, sb.pop_front()});
         end
      end
   end

   function automatic logic [KEY_LEN*8-1:0] packKey(input string s);
      logic [KEY_LEN*8-1:0] k = '0;
      for (int i = 0; i < s.len(); i++) k[i*8 +: 8] = s[i];
      return k;
   endfunction

   task automatic loadKey(input string s, input int len);
      key_in  = packKey(s);
      key_len = IDX_W'(len);
      LOAD    = 1'b1;
      @(posedge CLK); #1;
      LOAD    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   // Called at posedge+1; each char waits for in_ready, bounded
   task automatic sendStr(input string s, input string exp, input logic m);
      for (int i = 0; i < s.len(); i++) begin
         int waited = 0;
         in_valid = 1'b1;
         in_char  = s[i];
         mode     = m;
         @(negedge CLK);
         while (!in_ready && waited < 200) begin
            @(negedge CLK);
            waited++;
         end
         if (!in_ready) begin
            cmpCount++;
            errCount++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
         end else begin
            sb.push_back(exp[i]);
         end
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_in_ready",   {31'd0, in_ready},   0);
      check("rst_out_valid",  {31'd0, out_valid},  0);
      check("rst_out_char",   {24'd0, out_char},   0);
      check("rst_keyed",      {31'd0, keyed},      0);
      check("rst_char_count", {16'd0, char_count}, 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      idle(1);

      // Classic LEMON encrypt, then decrypt with a reload
      loadKey("LEMON", 5);
      check("keyed_after_load", {31'd0, keyed}, 1);
      sendStr("ATTACKATDAWN", "LXFOPVEFRNHR", 1'b0);
      idle(3);
      check("count_lemon", {16'd0, char_count}, 12);
      loadKey("LEMON", 5);
      check("count_cleared", {16'd0, char_count}, 0);
      sendStr("LXFOPVEFRNHR", "ATTACKATDAWN", 1'b1);
      idle(3);

      // Wrap-around both directions
      loadKey("B", 1);
      sendStr("Z", "A", 1'b0);
      sendStr("A", "Z", 1'b1);
      idle(3);

      // Non-letter passes through and does not advance the key
      loadKey("LEMON", 5);
      sendStr("A A", "L E", 1'b0);
      idle(3);
      check("count_space", {16'd0, char_count}, 2);

      // Mode flip mid-stream keeps the index: decrypt 'A' with key 'E' -> 'W'
      loadKey("LEMON", 5);
      sendStr("A", "L", 1'b0);
      sendStr("A", "W", 1'b1);
      idle(3);

      // Backpressure: held output, no in_ready, then resume without loss
      loadKey("LEMON", 5);
      out_ready = 1'b0;
      sendStr("A", "L", 1'b0);
      fork
         sendStr("TT", "XF", 1'b0);
         begin
            repeat (3) begin
               @(negedge CLK);
               check("bp_in_ready",  {31'd0, in_ready},  0);
               check("bp_out_valid", {31'd0, out_valid}, 1);
               check("bp_out_char",  {24'd0, out_char},  76);
            end
            @(posedge CLK); #1;
            out_ready = 1'b1;
         end
      join
      idle(3);
      check("count_bp", {16'd0, char_count}, 3);

      // key_len 0 behaves as 1
      loadKey("LEMON", 0);
      sendStr("AAA", "LLL", 1'b0);
      idle(3);

      // key_len 15 clamps to 10
      loadKey("BCDEFGHIJK", 15);
      sendStr("AAAAAAAAAAA", "BCDEFGHIJKB", 1'b0);
      idle(3);

      // Mid-stream reset with a pending output
      loadKey("LEMON", 5);
      out_ready = 1'b0;
      sendStr("A", "L", 1'b0);
      RST_N = 1'b0;
      #2;
      check("mid_rst_out_valid",  {31'd0, out_valid},  0);
      check("mid_rst_keyed",      {31'd0, keyed},      0);
      check("mid_rst_in_ready",   {31'd0, in_ready},   0);
      check("mid_rst_char_count", {16'd0, char_count}, 0);
      sb.delete();
      @(posedge CLK); #1;
      RST_N     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_char   = "A";
      repeat (3) begin
         @(negedge CLK);
         check("nokey_in_ready", {31'd0, in_ready}, 0);
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      loadKey("LEMON", 5);
      sendStr("A", "L", 1'b0);
      idle(3);

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
